// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port-per-direction memory
// with registered (one-cycle) read data; responses return unconditionally.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_valid,
    input  logic                  b_valid,
    output logic                  a_ready,
    output logic                  b_ready,
    input  logic                  a_wr,
    input  logic                  b_wr,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  a_rsp_valid,
    output logic                  b_rsp_valid,
    output logic [DATA_WIDTH-1:0] a_rsp_data,
    output logic [DATA_WIDTH-1:0] b_rsp_data,
    output logic                  mem_rst,
    output logic                  mem_wr_enb,
    output logic                  mem_rd_enb,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [7:0]            conflict_cnt,
    output logic                  dbg_state_o
);
    // Handshake: a request transfers in any cycle where x_valid && x_ready are both high.
    // Ready is a pure function of the valids, the FSM state and last_grant.
    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

    state_t      state_q, state_d;
    logic        last_b_q, last_b_d;
    logic        a_rsp_q, a_rsp_d;
    logic        b_rsp_q, b_rsp_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        grant_a, grant_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= INIT;
            last_b_q <= 1'b1;
            a_rsp_q  <= 1'b0;
            b_rsp_q  <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            last_b_q <= last_b_d;
            a_rsp_q  <= a_rsp_d;
            b_rsp_q  <= b_rsp_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    // On a conflict, the requester that did not win last time gets the grant.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state_q == RUN) begin
            if (a_valid && b_valid) begin
                grant_a = last_b_q;
                grant_b = !last_b_q;
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end
    end

    always_comb begin
        last_b_d = last_b_q;
        if (grant_a || grant_b) begin
            last_b_d = grant_b;
        end
        a_rsp_d = grant_a && !a_wr;
        b_rsp_d = grant_b && !b_wr;
        cnt_d   = cnt_q;
        if (state_q == RUN && a_valid && b_valid && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_comb begin
        mem_wr_enb  = 1'b0;
        mem_rd_enb  = 1'b0;
        mem_wr_addr = '0;
        mem_rd_addr = '0;
        mem_wr_data = '0;
        if (grant_a) begin
            if (a_wr) begin
                mem_wr_enb  = 1'b1;
                mem_wr_addr = a_addr;
                mem_wr_data = a_wdata;
            end else begin
                mem_rd_enb  = 1'b1;
                mem_rd_addr = a_addr;
            end
        end else if (grant_b) begin
            if (b_wr) begin
                mem_wr_enb  = 1'b1;
                mem_wr_addr = b_addr;
                mem_wr_data = b_wdata;
            end else begin
                mem_rd_enb  = 1'b1;
                mem_rd_addr = b_addr;
            end
        end
    end

    assign a_ready      = grant_a;
    assign b_ready      = grant_b;
    assign mem_rst      = (state_q == INIT);
    assign a_rsp_valid  = a_rsp_q;
    assign b_rsp_valid  = b_rsp_q;
    assign a_rsp_data   = a_rsp_q ? mem_rd_data : '0;
    assign b_rsp_data   = b_rsp_q ? mem_rd_data : '0;
    assign conflict_cnt = cnt_q;
    assign dbg_state_o  = state_q;

endmodule
